// File: rtl/clock_display_scanner.sv
// clock_display_scanner: 4-digit multiplexed 7-segment driver for the alarm clock (HH:MM, colon, alarm dot)
// Ports: clk, rst_n (async active-low); hr_tens/hr_ones/min_tens/min_ones BCD time in;
// alarm_armed, tick_1hz, colon_blink control in; seg[6:0] (a..g), dp, dig_en[3:0] (bit0 = rightmost) out.
// Optional: define LEADING_ZERO_BLANK_EN to blank the hours-tens digit when it is zero.
module clock_display_scanner #(
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] hr_tens,
  input  logic [3:0] hr_ones,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_ones,
  input  logic       alarm_armed,
  input  logic       tick_1hz,
  input  logic       colon_blink,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] dig_en
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic [3:0] sh_ht, sh_ho, sh_mt, sh_mo;
  logic sh_alarm, colon_q;
  logic last, frame_end, off, dp_d;
  logic [3:0] digit, dig_d;
  logic [6:0] seg_d;
  assign last = cnt == CW'(SCAN_DIV - 1);
  assign frame_end = last && idx == 2'd3;
  assign digit = idx == 2'd0 ? sh_mo : idx == 2'd1 ? sh_mt : idx == 2'd2 ? sh_ho : sh_ht;
`ifdef LEADING_ZERO_BLANK_EN
  assign off = cnt < CW'(BLANK_CYCLES) || (idx == 2'd3 && sh_ht == 4'd0);
`else
  assign off = cnt < CW'(BLANK_CYCLES);
`endif
  always_comb begin
    seg_d = 7'h00;
    case (digit)
      4'd0: seg_d = 7'h3F;
      4'd1: seg_d = 7'h06;
      4'd2: seg_d = 7'h5B;
      4'd3: seg_d = 7'h4F;
      4'd4: seg_d = 7'h66;
      4'd5: seg_d = 7'h6D;
      4'd6: seg_d = 7'h7D;
      4'd7: seg_d = 7'h07;
      4'd8: seg_d = 7'h7F;
      4'd9: seg_d = 7'h6F;
      default: seg_d = 7'h40;
    endcase
  end
  assign dp_d = idx == 2'd2 ? colon_q : idx == 2'd0 ? sh_alarm : 1'b0;
  assign dig_d = 4'b0001 << idx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
      {sh_ht, sh_ho, sh_mt, sh_mo} <= 16'h0;
      sh_alarm <= 1'b0;
      colon_q <= 1'b1;
      seg <= 7'h00;
      dp <= 1'b0;
      dig_en <= 4'h0;
    end else begin
      cnt <= last ? '0 : cnt + 1'b1;
      idx <= last ? idx + 2'd1 : idx;
      if (frame_end) begin
        {sh_ht, sh_ho, sh_mt, sh_mo} <= {hr_tens, hr_ones, min_tens, min_ones};
        sh_alarm <= alarm_armed;
      end
      // dropping colon_blink forces the colon on, even over a same-cycle tick
      colon_q <= colon_blink ? colon_q ^ tick_1hz : 1'b1;
      seg <= off ? 7'h00 : seg_d;
      dp <= off ? 1'b0 : dp_d;
      dig_en <= off ? 4'h0 : dig_d;
    end
endmodule

// File: tb/tb_clock_display_scanner.sv
// tb_clock_display_scanner: directed frames with a scoreboard queue popped by an independent monitor
`timescale 1ns/100ps
module tb_clock_display_scanner;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] hr_tens, hr_ones, min_tens, min_ones;
  logic alarm_armed, tick_1hz, colon_blink;
  logic [6:0] seg;
  logic dp;
  logic [3:0] dig_en;
  typedef struct {
    logic [11:0] v;
    string tag;
  } exp_t;
  exp_t sb[$];
  exp_t cur;
  int vectors = 0;
  int miscompares = 0;
  int frame_no = 0;
  always #5 clk = ~clk;
  clock_display_scanner #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .hr_tens(hr_tens), .hr_ones(hr_ones),
    .min_tens(min_tens), .min_ones(min_ones), .alarm_armed(alarm_armed),
    .tick_1hz(tick_1hz), .colon_blink(colon_blink), .seg(seg), .dp(dp), .dig_en(dig_en)
  );
  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction
  task automatic push_zero(input string tag);
    exp_t e;
    e.v = 12'h000;
    e.tag = tag;
    sb.push_back(e);
  endtask
  // expected outputs for one frame showing the given shadow digits; slot 2 dp = col
  task automatic push_frame(input logic [3:0] ht, ho, mt, mo, input logic al, col, input int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      int s, c;
      logic [3:0] d, de;
      logic [6:0] sg;
      logic p;
      s = k / 8;
      c = k % 8;
      d = s == 0 ? mo : s == 1 ? mt : s == 2 ? ho : ht;
      sg = dec(d);
      p = s == 0 ? al : s == 2 ? col : 1'b0;
      de = 4'b0001 << s;
      if (c < 2) {sg, p, de} = 12'h000;
`ifdef LEADING_ZERO_BLANK_EN
      if (s == 3 && ht == 4'd0) {sg, p, de} = 12'h000;
`endif
      e.v = {sg, p, de};
      e.tag = $sformatf("f%0d_s%0d_c%0d", frame_no, s, c);
      sb.push_back(e);
    end
  endtask
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic frame(input logic [3:0] ht, ho, mt, mo, input logic al, col, tk);
    push_frame(ht, ho, mt, mo, al, col, 32);
    tick_1hz = tk;
    #5 tick_1hz = 1'b0;
    wait_cycles(32);
    frame_no++;
  endtask
  initial forever begin
    @(negedge clk or negedge rst_n);
    #0.1;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      vectors++;
      if ({seg, dp, dig_en} !== cur.v) begin
        miscompares++;
        $display("FAIL %s: got seg=%h dp=%b dig_en=%b, expected seg=%h dp=%b dig_en=%b",
                 cur.tag, seg, dp, dig_en, cur.v[11:5], cur.v[4], cur.v[3:0]);
      end
    end
  end
  initial begin
    rst_n = 1'b0;
    {hr_tens, hr_ones, min_tens, min_ones} = 16'h0;
    alarm_armed = 1'b0;
    tick_1hz = 1'b0;
    colon_blink = 1'b0;
    @(negedge clk);
    #1;
    push_zero("reset");
    wait_cycles(1);
    {hr_tens, hr_ones, min_tens, min_ones} = 16'h1234;
    alarm_armed = 1'b1;
    rst_n = 1'b1;
    frame(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b1, 1'b0);
    push_frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b1, 32);
    wait_cycles(12);
    min_ones = 4'd5;
    wait_cycles(20);
    frame_no++;
    min_tens = 4'hA;
    frame(4'd1, 4'd2, 4'd3, 4'd5, 1'b1, 1'b1, 1'b0);
    min_tens = 4'hF;
    frame(4'd1, 4'd2, 4'hA, 4'd5, 1'b1, 1'b1, 1'b0);
    min_tens = 4'd3;
    frame(4'd1, 4'd2, 4'hF, 4'd5, 1'b1, 1'b1, 1'b0);
    colon_blink = 1'b1;
    frame(4'd1, 4'd2, 4'd3, 4'd5, 1'b1, 1'b0, 1'b1);
    frame(4'd1, 4'd2, 4'd3, 4'd5, 1'b1, 1'b1, 1'b1);
    frame(4'd1, 4'd2, 4'd3, 4'd5, 1'b1, 1'b0, 1'b1);
    frame(4'd1, 4'd2, 4'd3, 4'd5, 1'b1, 1'b1, 1'b1);
    colon_blink = 1'b0;
    frame(4'd1, 4'd2, 4'd3, 4'd5, 1'b1, 1'b1, 1'b1);
    hr_tens = 4'd0;
    hr_ones = 4'd9;
    frame(4'd1, 4'd2, 4'd3, 4'd5, 1'b1, 1'b1, 1'b1);
    frame(4'd0, 4'd9, 4'd3, 4'd5, 1'b1, 1'b1, 1'b0);
    push_frame(4'd0, 4'd9, 4'd3, 4'd5, 1'b1, 1'b1, 20);
    wait_cycles(20);
    frame_no++;
    push_zero("async_reset");
    rst_n = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    frame(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
